fifo_push_arb: RTL and testbench
================================

Name: fifo_push_arb

Overview:
- Round-robin arbiter that shares the push side of one parameterized synchronous FIFO among NUM_REQ producers.
- Each producer uses a valid/ready handshake. The block drives the FIFO push strobe and data, and respects the FIFO full flag.
- A granted producer keeps ownership for a burst of up to MAX_BURST beats, so its data stays contiguous in the FIFO.
- Sits directly in front of the FIFO instance; the FIFO pop side is untouched.

Parameters:
- NUM_REQ, default 4, number of requesters (>=2).
- DATA_W, default 8, data width per requester and at the FIFO.
- MAX_BURST, default 4, maximum consecutive beats per grant (>=1).

Ports:
- clk  input  1  clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- req_valid_i  input  NUM_REQ  per-requester data valid.
- req_data_i  input  NUM_REQ*DATA_W  requester i data in bits [i*DATA_W +: DATA_W].
- req_ready_o  output  NUM_REQ  per-requester accept; at most one bit high.
- fifo_push_o  output  1  push strobe to the FIFO.
- fifo_push_data_o  output  DATA_W  data of the accepted beat.
- fifo_full_i  input  1  FIFO full flag.
- grant_vld_o  output  1  a transfer occurs this cycle.
- grant_id_o  output  $clog2(NUM_REQ)  index of the transferring requester; 0 when grant_vld_o=0.
- busy_o  output  1  high while in ST_BURST.

Behaviour:
- Transfer: beat i moves when req_valid_i[i] & req_ready_o[i]. That cycle: fifo_push_o=1, fifo_push_data_o=req_data_i[i], grant_vld_o=1, grant_id_o=i.
- Latency 0, fully combinational from requester to FIFO. No data storage in this block.
- Requesters hold valid and data stable until accepted.
- Registered state: state (ST_IDLE/ST_BURST), rr_ptr, owner, beat_cnt (width $clog2(MAX_BURST+1)).
- Reset values: state=ST_IDLE, rr_ptr=0, owner=0, beat_cnt=0.
- While reset is asserted, all outputs are forced to 0: req_ready_o, fifo_push_o, fifo_push_data_o, grant_vld_o, grant_id_o, busy_o.
- Reset mid-burst abandons the burst; beats already pushed remain in the FIFO.
- ST_IDLE:
  - winner = first requester with valid set, searching from rr_ptr upward with wrap-around modulo NUM_REQ.
  - req_ready_o[winner] = ~fifo_full_i.
  - Transfer with MAX_BURST=1: stay in ST_IDLE, rr_ptr<=winner+1 (mod NUM_REQ).
  - Transfer with MAX_BURST>1: go to ST_BURST, owner<=winner, beat_cnt<=1.
  - No valid, or fifo_full_i=1: no transfer; state and rr_ptr unchanged.
- ST_BURST:
  - Only owner is eligible: req_ready_o[owner] = ~fifo_full_i; all other ready bits are 0.
  - Transfer with beat_cnt+1==MAX_BURST: go to ST_IDLE, rr_ptr<=owner+1, beat_cnt<=0.
  - Transfer otherwise: beat_cnt<=beat_cnt+1.
  - Owner valid low: no transfer; go to ST_IDLE, rr_ptr<=owner+1, beat_cnt<=0. The release costs one cycle.
  - fifo_full_i=1 with owner valid: stall; all state holds and the burst is not broken.
- Wrap-around: rr_ptr increment from NUM_REQ-1 goes to 0. Non-power-of-2 NUM_REQ is supported and must never index out of range.
- Starvation bound: every continuously valid requester is accepted within (NUM_REQ-1)*MAX_BURST + NUM_REQ non-full cycles.

Decomposition:
- Package fifo_push_arb_pkg: typedef enum arb_state_t {ST_IDLE, ST_BURST}.
- One combinational sub-module rr_pick: inputs req vector and ptr; outputs one-hot grant, grant index, any_valid. Parameterized by NUM_REQ.
- The top level holds the FSM, counter and data mux.

Test Plan:
- Reset: hold reset=0 with all req_valid_i=1 -> all outputs 0; release -> first accepted beat has grant_id_o=0.
- Round-robin, MAX_BURST=1, all 4 valid, never full -> grant_id_o sequence 0,1,2,3,0,1, one push per cycle.
- Burst, MAX_BURST=4, requesters 1 and 2 always valid -> four beats from 1, then four from 2, then 1 again. busy_o is high from after beat 1 until the cycle after beat 4.
- Early release: owner 3 drops valid after 2 beats -> one idle cycle with fifo_push_o=0, then requester 0 is granted (rr_ptr wrapped to 0).
- Full stall: fifo_full_i=1 for 3 cycles mid-burst at beat_cnt=2 -> req_ready_o=0 and fifo_push_o=0 throughout. After release, beats 3 and 4 come from the same owner with the data order preserved.
- Integrated with the FIFO (DEPTH=4): three requesters push tagged data until the FIFO reports full -> popped order matches the grant log. No beat is lost or duplicated, and no push is issued while full.

Source files
------------

// File: rtl/fifo_push_arb_pkg.sv
// fifo_push_arb_pkg: shared types for the round-robin FIFO push arbiter
package fifo_push_arb_pkg;
  typedef enum logic {ST_IDLE, ST_BURST} arb_state_t;
endpackage

// File: rtl/fifo_push_arb_if.sv
// fifo_push_arb_if: requester handshakes, FIFO push port and grant status
interface fifo_push_arb_if #(parameter int NUM_REQ = 4, parameter int DATA_W = 8);
  logic [NUM_REQ-1:0]         req_valid_i;
  logic [NUM_REQ*DATA_W-1:0]  req_data_i;
  logic [NUM_REQ-1:0]         req_ready_o;
  logic                       fifo_push_o;
  logic [DATA_W-1:0]          fifo_push_data_o;
  logic                       fifo_full_i;
  logic                       grant_vld_o;
  logic [$clog2(NUM_REQ)-1:0] grant_id_o;
  logic                       busy_o;
  modport master (
    input  req_valid_i, req_data_i, fifo_full_i,
    output req_ready_o, fifo_push_o, fifo_push_data_o, grant_vld_o, grant_id_o, busy_o
  );
  modport slave (
    output req_valid_i, req_data_i, fifo_full_i,
    input  req_ready_o, fifo_push_o, fifo_push_data_o, grant_vld_o, grant_id_o, busy_o
  );
endinterface

// File: rtl/fifo_push_arb_rr_pick.sv
// fifo_push_arb_rr_pick: first valid requester searching upward from ptr with wrap-around
module fifo_push_arb_rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       any
);
  localparam int IW = $clog2(NUM_REQ);
  logic [IW-1:0] j;
  // Scan farthest-first so the nearest valid requester overwrites; modulo keeps j in range
  always_comb begin
    gnt = '0;
    idx = '0;
    j = '0;
    any = |req;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % NUM_REQ);
      if (req[j]) begin
        gnt = NUM_REQ'(1) << j;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/fifo_push_arb.sv
// fifo_push_arb: round-robin sharing of one FIFO push port among NUM_REQ producers,
// with grants held for bursts of up to MAX_BURST beats
module fifo_push_arb
  import fifo_push_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input logic             clk,
  input logic             reset,
  fifo_push_arb_if.master bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_t         state_q, state_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d, owner_q, owner_d, pick_idx, sel;
  logic [CW-1:0]      beat_cnt_q, beat_cnt_d;
  logic [NUM_REQ-1:0] pick_gnt;
  logic               pick_any, burst, elig, xfer, last;

  fifo_push_arb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req(bus.req_valid_i),
    .ptr(rr_ptr_q),
    .gnt(pick_gnt),
    .idx(pick_idx),
    .any(pick_any)
  );

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] x);
    return (int'(x) == NUM_REQ - 1) ? '0 : x + IW'(1);
  endfunction

  // Outputs are gated by reset so everything reads 0 while reset is held
  always_comb begin
    burst = state_q == ST_BURST;
    sel = burst ? owner_q : pick_idx;
    elig = reset & ~bus.fifo_full_i & (burst | pick_any);
    xfer = elig & bus.req_valid_i[sel];
    last = beat_cnt_q + CW'(1) == CW'(MAX_BURST);
    bus.req_ready_o = !elig ? '0 : burst ? NUM_REQ'(1) << owner_q : pick_gnt;
    bus.fifo_push_o = xfer;
    bus.grant_vld_o = xfer;
    bus.grant_id_o = xfer ? sel : '0;
    bus.fifo_push_data_o = xfer ? bus.req_data_i[int'(sel)*DATA_W +: DATA_W] : '0;
    bus.busy_o = reset & burst;
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d = owner_q;
    beat_cnt_d = beat_cnt_q;
    // A dropped owner valid ends the burst; a full FIFO merely stalls it
    if (burst && (!bus.req_valid_i[owner_q] || (xfer && last))) begin
      state_d = ST_IDLE;
      rr_ptr_d = nxt(owner_q);
      beat_cnt_d = '0;
    end else if (burst && xfer) begin
      beat_cnt_d = beat_cnt_q + CW'(1);
    end else if (xfer && MAX_BURST == 1) begin
      rr_ptr_d = nxt(sel);
    end else if (xfer) begin
      state_d = ST_BURST;
      owner_d = sel;
      beat_cnt_d = CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      rr_ptr_q <= '0;
      owner_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q <= owner_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end
endmodule

// File: tb/tb_fifo_push_arb.sv
// tb_fifo_push_arb: directed scoreboard bench for round-robin, bursts, release, stall and FIFO fill
module tb_fifo_push_arb;
  localparam int N = 4;
  localparam int W = 8;

  typedef struct {logic full; logic vld; logic [1:0] id; logic busy; logic [7:0] data;} ent_t;
  typedef struct {logic [1:0] id; logic [7:0] data;} log_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_assert = 0;
  int n_fail = 0;
  int left[N];
  int seq[N];
  int eseq[N];
  ent_t sb[$];
  logic [7:0] fq[$];
  log_t glog[$];

  always #5 clk = ~clk;

  fifo_push_arb_if #(.NUM_REQ(N), .DATA_W(W)) b1 ();
  fifo_push_arb_if #(.NUM_REQ(N), .DATA_W(W)) b4 ();

  fifo_push_arb #(.NUM_REQ(N), .DATA_W(W), .MAX_BURST(1)) dut1 (.clk(clk), .reset(reset), .bus(b1.master));
  fifo_push_arb #(.NUM_REQ(N), .DATA_W(W), .MAX_BURST(4)) dut4 (.clk(clk), .reset(reset), .bus(b4.master));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Each requester offers data {id, seq} while it still has beats left
  task automatic drive4();
    for (int i = 0; i < N; i++) begin
      b4.req_valid_i[i] = left[i] > 0;
      b4.req_data_i[i*W +: W] = {2'(i), 6'(seq[i])};
    end
  endtask

  task automatic sb_add(input logic full, input logic vld, input logic [1:0] id, input logic busy);
    ent_t e;
    e.full = full;
    e.vld = vld;
    e.id = vld ? id : 2'd0;
    e.busy = busy;
    e.data = {id, 6'(eseq[id])};
    if (vld) eseq[id]++;
    sb.push_back(e);
  endtask

  task automatic tick4();
    logic [N-1:0] acc;
    acc = b4.req_valid_i & b4.req_ready_o;
    chk("ready_onehot0", 32'($onehot0(b4.req_ready_o)), 32'd1);
    if (b4.fifo_full_i) chk("ready_while_full", 32'(b4.req_ready_o), 32'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        seq[i]++;
        if (left[i] > 0) left[i]--;
      end
    end
    drive4();
  endtask

  task automatic run_sb();
    ent_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      b4.fifo_full_i = e.full;
      @(negedge clk);
      chk("push", 32'(b4.fifo_push_o), 32'(e.vld));
      chk("grant_vld", 32'(b4.grant_vld_o), 32'(e.vld));
      chk("busy", 32'(b4.busy_o), 32'(e.busy));
      chk("grant_id", 32'(b4.grant_id_o), 32'(e.id));
      if (e.vld) chk("push_data", 32'(b4.fifo_push_data_o), 32'(e.data));
      tick4();
    end
  endtask

  task automatic fifo_cycle();
    log_t g;
    b4.fifo_full_i = fq.size() >= 4;
    @(negedge clk);
    if (b4.fifo_push_o) begin
      chk("push_while_full", 32'(b4.fifo_full_i), 32'd0);
      g.id = b4.grant_id_o;
      g.data = b4.fifo_push_data_o;
      fq.push_back(g.data);
      glog.push_back(g);
    end
    tick4();
  endtask

  initial begin
    int s0;
    logic [7:0] d;
    log_t g;
    for (int i = 0; i < N; i++) begin
      left[i] = 1;
      seq[i] = 0;
      eseq[i] = 0;
    end
    b1.req_valid_i = '1;
    b1.fifo_full_i = 1'b0;
    for (int i = 0; i < N; i++) b1.req_data_i[i*W +: W] = 8'hA0 + 8'(i);
    b4.fifo_full_i = 1'b0;
    drive4();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready1", 32'(b1.req_ready_o), 32'd0);
    chk("rst_push1", 32'(b1.fifo_push_o), 32'd0);
    chk("rst_data1", 32'(b1.fifo_push_data_o), 32'd0);
    chk("rst_gvld1", 32'(b1.grant_vld_o), 32'd0);
    chk("rst_gid1", 32'(b1.grant_id_o), 32'd0);
    chk("rst_busy1", 32'(b1.busy_o), 32'd0);
    chk("rst_ready4", 32'(b4.req_ready_o), 32'd0);
    chk("rst_push4", 32'(b4.fifo_push_o), 32'd0);
    chk("rst_data4", 32'(b4.fifo_push_data_o), 32'd0);
    chk("rst_gvld4", 32'(b4.grant_vld_o), 32'd0);
    chk("rst_gid4", 32'(b4.grant_id_o), 32'd0);
    chk("rst_busy4", 32'(b4.busy_o), 32'd0);
    for (int i = 0; i < N; i++) left[i] = 0;
    drive4();
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rr_push", 32'(b1.fifo_push_o), 32'd1);
      chk("rr_id", 32'(b1.grant_id_o), 32'(k % 4));
      chk("rr_data", 32'(b1.fifo_push_data_o), 32'(8'hA0 + 8'(k % 4)));
    end
    @(posedge clk);
    #1;
    b1.req_valid_i = '0;

    left[1] = 5;
    left[2] = 4;
    drive4();
    sb_add(0, 1, 1, 0);
    repeat (3) sb_add(0, 1, 1, 1);
    sb_add(0, 1, 2, 0);
    repeat (3) sb_add(0, 1, 2, 1);
    sb_add(0, 1, 1, 0);
    sb_add(0, 0, 0, 1);
    sb_add(0, 0, 0, 0);
    run_sb();

    left[3] = 2;
    left[0] = 4;
    drive4();
    sb_add(0, 1, 3, 0);
    sb_add(0, 1, 3, 1);
    sb_add(0, 0, 0, 1);
    sb_add(0, 1, 0, 0);
    repeat (3) sb_add(0, 1, 0, 1);
    sb_add(0, 0, 0, 0);
    run_sb();

    left[2] = 4;
    drive4();
    sb_add(0, 1, 2, 0);
    sb_add(0, 1, 2, 1);
    repeat (3) sb_add(1, 0, 0, 1);
    repeat (2) sb_add(0, 1, 2, 1);
    sb_add(0, 0, 0, 0);
    run_sb();

    for (int i = 0; i < 3; i++) left[i] = 100;
    drive4();
    for (int p = 0; p < 3; p++) begin
      s0 = seq[p];
      repeat (7) fifo_cycle();
      chk("fifo_level", 32'(fq.size()), 32'd4);
      chk("log_level", 32'(glog.size()), 32'd4);
      for (int k = 0; k < 4; k++) begin
        if (fq.size() > 0 && glog.size() > 0) begin
          d = fq.pop_front();
          g = glog.pop_front();
          chk("pop_vs_log", 32'(d), 32'(g.data));
          chk("log_id", 32'(g.id), 32'(p));
          chk("pop_order", 32'(d), 32'({2'(p), 6'(s0 + k)}));
        end
      end
      fq.delete();
      glog.delete();
    end
    for (int i = 0; i < N; i++) left[i] = 0;
    drive4();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
